// File: rtl/load_store_unit.sv
// Memory-access stage in front of a word-wide DataMemory: lane-extracting loads,
// read-modify-write for byte/halfword stores, and error responses that never touch memory.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [16:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [14:0] data_address,
    output logic        write_en,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_next;
    logic        accept;
    logic        acc_err;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] old_word;

    function automatic logic req_bad(input logic [1:0] size, input logic [16:0] addr);
        logic bad;
        bad = (size == 2'b11)
           || (size == 2'b01 && addr[0])
           || (size == 2'b10 && addr[1:0] != 2'b00)
           || ({17'd0, addr[16:2]} >= MEM_WORDS);
        return bad;
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] offset, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] insert_lane(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] offset);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: r[{offset, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (offset[1]) r[31:16] = wdata[15:0];
                else           r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign acc_err   = req_bad(req_size, req_addr);

    // Strobes come straight from the state register so they cannot glitch and
    // drop together with the asynchronous reset.
    assign write_en   = (state == WR);
    assign resp_valid = (state == RESP);
    assign write_data = (state == WR) ? insert_lane(old_word, wdata_q, size_q, offset_q) : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_err)                 state_next = RESP;
                    else if (!req_write)         state_next = RD;
                    else if (req_size == 2'b10)  state_next = WR;
                    else                         state_next = RD;
                end
            end
            RD:      state_next = write_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            offset_q     <= 2'b00;
            wdata_q      <= 32'd0;
            old_word     <= 32'd0;
            data_address <= 15'd0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        write_q  <= req_write;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        offset_q <= req_addr[1:0];
                        wdata_q  <= req_wdata;
                        resp_err <= acc_err;
                        resp_rdata <= 32'd0;
                        // Rejected requests leave the memory port address untouched.
                        if (!acc_err) data_address <= req_addr[16:2];
                    end
                end
                RD: begin
                    old_word <= read_data;
                    if (!write_q) resp_rdata <= extract_lane(read_data, size_q, offset_q, signed_q);
                end
                RESP: begin
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
